// File: rtl/dualmem_narrow_reader_pkg.sv
// Shared constants and helpers for the 16/64-bit asymmetric buffer read path.
package dualmem_pkg;

  localparam int HW_PER_WORD = 4;
  localparam int NARROW_W    = 16;
  localparam int WIDE_W      = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Little-endian halfword k of a wide word.
  function automatic logic [NARROW_W-1:0] halfword_sel(
    input logic [WIDE_W-1:0] word,
    input logic [1:0]        idx
  );
    logic [NARROW_W-1:0] half;
    half = 16'h0000;
    case (idx)
      2'd0:    half = word[15:0];
      2'd1:    half = word[31:16];
      2'd2:    half = word[47:32];
      2'd3:    half = word[63:48];
      default: half = 16'h0000;
    endcase
    return half;
  endfunction

endpackage

// File: rtl/dualmem_narrow_reader_if.sv
// Command, wide-port and narrow-stream signals of the buffer read engine.
interface dualmem_narrow_reader_if #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 13
);
  import dualmem_pkg::*;

  logic                start;
  logic                abort;
  logic [ADDR_W-1:0]   base_addr;
  logic [LEN_W-1:0]    len;
  logic                busy;
  logic                done;
  logic                mem_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WIDE_W-1:0]   mem_dout;
  logic [NARROW_W-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                tx_last;

  modport master (
    input  start, abort, base_addr, len, mem_dout, tx_ready,
    output busy, done, mem_en, mem_addr, tx_data, tx_valid, tx_last
  );

  modport slave (
    output start, abort, base_addr, len, mem_dout, tx_ready,
    input  busy, done, mem_en, mem_addr, tx_data, tx_valid, tx_last
  );

endinterface

// File: rtl/dualmem_narrow_reader_fifo2.sv
// Two-entry wide-word FIFO that also tracks which halfword of the head word is next.
module dualmem_word_fifo2
  import dualmem_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                push,
  input  logic [WIDE_W-1:0]   push_data,
  input  logic                pop,
  input  logic                adv,
  output logic [1:0]          count,
  output logic [1:0]          head_idx,
  output logic [NARROW_W-1:0] head_half
);

  logic [WIDE_W-1:0] slot0_r;
  logic [WIDE_W-1:0] slot1_r;
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic [1:0]        idx_r;
  logic              do_push_s;
  logic              do_pop_s;
  logic [WIDE_W-1:0] head_word_s;

  // Qualify push/pop against occupancy and select the head slot.
  always_comb begin
    do_pop_s  = pop && (count_r != 2'd0);
    do_push_s = push && ((count_r != 2'd2) || do_pop_s);
    if (rd_ptr_r) begin
      head_word_s = slot1_r;
    end else begin
      head_word_s = slot0_r;
    end
  end

  // Storage, pointers, occupancy and head halfword index.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot0_r  <= 64'h0;
      slot1_r  <= 64'h0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      idx_r    <= 2'd0;
    end else if (flush) begin
      slot0_r  <= 64'h0;
      slot1_r  <= 64'h0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      idx_r    <= 2'd0;
    end else begin
      if (do_push_s) begin
        if (wr_ptr_r) begin
          slot1_r <= push_data;
        end else begin
          slot0_r <= push_data;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (do_pop_s) begin
        idx_r <= 2'd0;
      end else if (adv && (count_r != 2'd0)) begin
        idx_r <= idx_r + 2'd1;
      end
    end
  end

  assign count     = count_r;
  assign head_idx  = idx_r;
  assign head_half = halfword_sel(head_word_s, idx_r);

endmodule

// File: rtl/dualmem_narrow_reader.sv
// Drains an asymmetric buffer through its 64-bit port and streams 16-bit halfwords
// over valid/ready, keeping at most two words buffered or in flight.
module dualmem_narrow_reader
  import dualmem_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 13
)
(
  input logic                      clk,
  input logic                      rstn,
  dualmem_narrow_reader_if.master  bus
);

  state_t              state_r;
  logic                busy_r;
  logic                done_r;
  logic                mem_en_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [ADDR_W-1:0]   next_addr_r;
  logic [LEN_W-1:0]    words_left_r;
  logic [LEN_W-1:0]    hw_left_r;
  logic                rvalid_r;

  logic [1:0]          fifo_count_s;
  logic [1:0]          fifo_idx_s;
  logic [NARROW_W-1:0] fifo_half_s;

  logic                accept_s;
  logic                empty_cmd_s;
  logic                tx_valid_s;
  logic                hs_s;
  logic                last_s;
  logic                last_hs_s;
  logic [2:0]          outstanding_s;
  logic                issue_s;
  logic                pop_s;
  logic                flush_s;
  logic                push_s;
  logic [LEN_W:0]      len_round_s;
  logic [LEN_W-1:0]    words_total_s;
  logic [NARROW_W-1:0] tx_data_s;

  // Command decode, issue throttling and stream handshake.
  always_comb begin
    accept_s      = (state_r == ST_IDLE) && bus.start && !bus.abort && (bus.len != '0);
    empty_cmd_s   = (state_r == ST_IDLE) && bus.start && !bus.abort && (bus.len == '0);
    len_round_s   = {1'b0, bus.len} + (LEN_W+1)'(HW_PER_WORD - 1);
    words_total_s = {1'b0, len_round_s[LEN_W:2]};
    tx_valid_s    = (fifo_count_s != 2'd0);
    hs_s          = tx_valid_s && bus.tx_ready;
    last_s        = tx_valid_s && (hw_left_r == LEN_W'(1));
    last_hs_s     = hs_s && last_s;
    outstanding_s = {1'b0, fifo_count_s} + {2'b00, mem_en_r} + {2'b00, rvalid_r};
    // Occupancy plus in-flight below two means returning RAM data always has a slot.
    issue_s       = (state_r == ST_RUN) && !bus.abort && (words_left_r != '0)
                    && (outstanding_s < 3'd2) && !last_hs_s;
    pop_s         = hs_s && ((fifo_idx_s == 2'(HW_PER_WORD - 1)) || last_s);
    flush_s       = bus.abort || last_hs_s;
    push_s        = rvalid_r;
    if (tx_valid_s) begin
      tx_data_s = fifo_half_s;
    end else begin
      tx_data_s = 16'h0000;
    end
  end

  // Transfer FSM, read address/issue counters and halfword countdown.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_addr_r   <= '0;
      next_addr_r  <= '0;
      words_left_r <= '0;
      hw_left_r    <= '0;
      rvalid_r     <= 1'b0;
    end else if (bus.abort) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      mem_en_r     <= 1'b0;
      words_left_r <= '0;
      hw_left_r    <= '0;
      rvalid_r     <= 1'b0;
    end else begin
      rvalid_r <= mem_en_r;
      case (state_r)
        ST_IDLE: begin
          done_r   <= empty_cmd_s;
          mem_en_r <= accept_s;
          if (accept_s) begin
            state_r      <= ST_RUN;
            busy_r       <= 1'b1;
            mem_addr_r   <= bus.base_addr;
            next_addr_r  <= bus.base_addr + ADDR_W'(1);
            words_left_r <= words_total_s - LEN_W'(1);
            hw_left_r    <= bus.len;
          end
        end
        ST_RUN: begin
          mem_en_r <= issue_s;
          if (issue_s) begin
            mem_addr_r   <= next_addr_r;
            next_addr_r  <= next_addr_r + ADDR_W'(1);
            words_left_r <= words_left_r - LEN_W'(1);
          end
          if (hs_s) begin
            hw_left_r <= hw_left_r - LEN_W'(1);
          end
          if (last_hs_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          done_r   <= 1'b0;
          mem_en_r <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          mem_en_r <= 1'b0;
        end
      endcase
    end
  end

  dualmem_word_fifo2 u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (bus.mem_dout),
    .pop       (pop_s),
    .adv       (hs_s),
    .count     (fifo_count_s),
    .head_idx  (fifo_idx_s),
    .head_half (fifo_half_s)
  );

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.mem_en   = mem_en_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.tx_data  = tx_data_s;
  assign bus.tx_valid = tx_valid_s;
  assign bus.tx_last  = last_s;

endmodule
